// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one single-port memory bus between fetch (read-only) and the memory stage (load/store); optional perf counters under CORE_ARB_PERF_EN
module core_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_MEM_STREAK = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic                    if_flush_i,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_stall_o,
  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_be_i,
  output logic                    mem_rvalid_o,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_stall_o,
`ifdef CORE_ARB_PERF_EN
  output logic [CNT_WIDTH-1:0]    arb_conflict_cnt_o,
  output logic [CNT_WIDTH-1:0]    arb_flush_drop_cnt_o,
`endif
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  output logic [DATA_WIDTH/8-1:0] bus_be_o,
  input  logic                    bus_gnt_i,
  input  logic                    bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i
);
  localparam int SW = $clog2(MAX_MEM_STREAK + 1);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;
  state_t                  r_state, w_next;
  owner_t                  r_owner;
  logic                    r_drop;
  logic [SW-1:0]           r_streak;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_be;
  logic                    w_if_req, w_mem_win, w_if_win, w_if_rsp, w_if_sup;
  assign w_if_req     = if_req_i & ~if_flush_i;
  assign w_mem_win    = (r_state == IDLE) & mem_req_i & ~((r_streak == SW'(MAX_MEM_STREAK)) & w_if_req);
  assign w_if_win     = (r_state == IDLE) & w_if_req & ~w_mem_win;
  assign w_if_rsp     = (r_state == RSP) & (r_owner == OWN_IF) & bus_rvalid_i;
  assign w_if_sup     = w_if_rsp & (r_drop | if_flush_i);
  assign if_rvalid_o  = w_if_rsp & ~r_drop & ~if_flush_i;
  assign mem_rvalid_o = (r_state == RSP) & (r_owner == OWN_MEM) & bus_rvalid_i;
  assign if_rdata_o   = bus_rdata_i;
  assign mem_rdata_o  = bus_rdata_i;
  assign if_stall_o   = if_req_i & ~if_rvalid_o;
  assign mem_stall_o  = mem_req_i & ~mem_rvalid_o;
  assign bus_req_o    = r_state == REQ;
  assign bus_we_o     = r_we;
  assign bus_addr_o   = r_addr;
  assign bus_wdata_o  = r_wdata;
  assign bus_be_o     = r_be;
  // next state: arbitrate in IDLE, wait for grant, wait for the single response
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && (w_mem_win || w_if_win)) w_next = REQ;
    if (r_state == REQ && bus_gnt_i) w_next = RSP;
    if (r_state == RSP && bus_rvalid_i) w_next = IDLE;
  end
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  // winner capture, drop flag and fetch starvation guard
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner  <= OWN_NONE;
      r_drop   <= 1'b0;
      r_streak <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
    end else begin
      if (w_mem_win || w_if_win) begin
        r_we    <= w_mem_win & mem_we_i;
        r_addr  <= w_mem_win ? mem_addr_i : if_addr_i;
        r_wdata <= w_mem_win ? mem_wdata_i : '0;
        r_be    <= w_mem_win ? mem_be_i : '0;
      end
      r_owner  <= w_mem_win ? OWN_MEM : w_if_win ? OWN_IF : (w_next == IDLE) ? OWN_NONE : r_owner;
      r_drop   <= (w_next == IDLE) ? 1'b0 : r_drop | (if_flush_i & (r_owner == OWN_IF) & (r_state != IDLE));
      r_streak <= (!if_req_i || w_if_win) ? '0 :
                  (w_mem_win && r_streak != SW'(MAX_MEM_STREAK)) ? r_streak + 1'b1 : r_streak;
    end
  end
`ifdef CORE_ARB_PERF_EN
  logic [CNT_WIDTH-1:0] r_conflict_cnt, r_drop_cnt;
  assign arb_conflict_cnt_o   = r_conflict_cnt;
  assign arb_flush_drop_cnt_o = r_drop_cnt;
  // saturating counters for arbitration conflicts and suppressed fetch responses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_conflict_cnt <= '0;
      r_drop_cnt     <= '0;
    end else begin
      if (if_req_i && mem_req_i && r_state == IDLE && !(&r_conflict_cnt)) r_conflict_cnt <= r_conflict_cnt + 1'b1;
      if (w_if_sup && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: scoreboard bench for core_mem_arbiter with a behavioural bus model
module tb_core_mem_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_flush_i, if_rvalid_o, if_stall_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        mem_req_i, mem_we_i, mem_rvalid_o, mem_stall_o;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [3:0]  mem_be_i;
  logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;
`ifdef CORE_ARB_PERF_EN
  logic [15:0] conflict_cnt, drop_cnt;
`endif
  int          checks = 0;
  int          errors = 0;
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [32:0] bus_log[$];
  logic [31:0] bmem[logic [31:0]];
  int          gnt_delay = 0;
  int          rsp_delay = 1;
  int          bus_rsp_cnt = 0;

  always #5 clk_i = ~clk_i;

  core_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_be_i(mem_be_i),
    .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .mem_stall_o(mem_stall_o),
`ifdef CORE_ARB_PERF_EN
    .arb_conflict_cnt_o(conflict_cnt), .arb_flush_drop_cnt_o(drop_cnt),
`endif
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // bus model: grant after gnt_delay cycles of bus_req_o, respond rsp_delay cycles after grant
  initial begin
    int          gc, pc;
    logic [31:0] pd, w;
    gc = 0;
    pc = 0;
    pd = '0;
    bmem[32'h100] = 32'h0050_0093;
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      bus_gnt_i = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i = '0;
      if (pc > 0) begin
        pc--;
        if (pc == 0) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i = pd;
          bus_rsp_cnt++;
        end
      end else if (bus_req_o) begin
        if (gc < gnt_delay) gc++;
        else begin
          gc = 0;
          bus_gnt_i = 1'b1;
          pc = rsp_delay;
          bus_log.push_back({bus_we_o, bus_addr_o});
          w = bmem.exists(bus_addr_o) ? bmem[bus_addr_o] : pat(bus_addr_o);
          if (bus_we_o) begin
            for (int b = 0; b < 4; b++) if (bus_be_o[b]) w[8*b +: 8] = bus_wdata_o[8*b +: 8];
            bmem[bus_addr_o] = w;
            pd = '0;
          end else pd = w;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] e);
    bit seen, gap;
    seen = 0;
    gap = 0;
    if_q.push_back(e);
    if_req_i = 1'b1;
    if_addr_i = a;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (if_rvalid_o) seen = 1;
      else if (!if_stall_o) gap = 1;
    end
    checks++;
    if (!seen || gap) begin
      errors++;
      $display("FAIL fetch_%h: seen=%0d stall_gap=%0d, required seen=1 stall_gap=0", a, seen, gap);
    end
    @(posedge clk_i);
    #1;
    if_req_i = 1'b0;
  endtask

  task automatic mem_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] e);
    bit seen, gap;
    seen = 0;
    gap = 0;
    mem_q.push_back(e);
    mem_req_i = 1'b1;
    mem_we_i = we;
    mem_addr_i = a;
    mem_wdata_i = d;
    mem_be_i = be;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (mem_rvalid_o) seen = 1;
      else if (!mem_stall_o) gap = 1;
    end
    checks++;
    if (!seen || gap) begin
      errors++;
      $display("FAIL mem_%h: seen=%0d stall_gap=%0d, required seen=1 stall_gap=0", a, seen, gap);
    end
    @(posedge clk_i);
    #1;
    mem_req_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, if_rvalid_o, mem_rvalid_o, if_stall_o, mem_stall_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h be=%h rv=%b%b stall=%b%b, required all 0",
               bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, if_rvalid_o, mem_rvalid_o, if_stall_o, mem_stall_o);
    end
`ifdef CORE_ARB_PERF_EN
    checks++;
    if ({conflict_cnt, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_perf: conflict=%0d drop=%0d, required 0 0", conflict_cnt, drop_cnt);
    end
`endif
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: bus_req_o=%b, required 0", bus_req_o);
    end
  endtask

  task automatic test_single_fetch;
    @(posedge clk_i);
    #1;
    if_q.push_back(32'h0050_0093);
    if_req_i = 1'b1;
    if_addr_i = 32'h100;
    @(negedge clk_i);
    checks++;
    if ({if_stall_o, bus_req_o} !== 2'b10) begin
      errors++;
      $display("FAIL single_c0: stall=%b req=%b, required 1 0", if_stall_o, bus_req_o);
    end
    @(negedge clk_i);
    checks++;
    if ({if_stall_o, bus_req_o, bus_we_o, bus_addr_o} !== {3'b110, 32'h100}) begin
      errors++;
      $display("FAIL single_c1: stall=%b req=%b we=%b addr=%h, required 1 1 0 00000100", if_stall_o, bus_req_o, bus_we_o, bus_addr_o);
    end
    @(negedge clk_i);
    checks++;
    if ({if_rvalid_o, if_stall_o} !== 2'b10) begin
      errors++;
      $display("FAIL single_c2: rvalid=%b stall=%b, required 1 0", if_rvalid_o, if_stall_o);
    end
    @(posedge clk_i);
    #1;
    if_req_i = 1'b0;
  endtask

  task automatic test_conflict;
    int n;
    @(posedge clk_i);
    #1;
    n = bus_log.size();
    fork
      mem_op(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 32'h0);
      fetch(32'h104, pat(32'h104));
    join
    checks++;
    if (bus_log.size() < n + 2 || bus_log[n] !== {1'b1, 32'h200} || bus_log[n+1] !== {1'b0, 32'h104}) begin
      errors++;
      $display("FAIL conflict_order: count=%0d first=%h second=%h, required 2 1_00000200 0_00000104",
               bus_log.size() - n, bus_log.size() > n ? bus_log[n] : 33'h0, bus_log.size() > n + 1 ? bus_log[n+1] : 33'h0);
    end
    mem_op(1'b0, 32'h200, 32'h0, 4'h0, 32'hDEAD_BEEF);
  endtask

  task automatic test_streak;
    int          n;
    logic [32:0] exp_log[7];
    for (int i = 0; i < 4; i++) exp_log[i] = {1'b0, 32'h400 + 32'(4 * i)};
    exp_log[4] = {1'b0, 32'h108};
    exp_log[5] = {1'b0, 32'h410};
    exp_log[6] = {1'b0, 32'h414};
    @(posedge clk_i);
    #1;
    n = bus_log.size();
    fork
      fetch(32'h108, pat(32'h108));
      for (int i = 0; i < 6; i++) mem_op(1'b0, 32'h400 + 32'(4 * i), 32'h0, 4'h0, pat(32'h400 + 32'(4 * i)));
    join
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (bus_log.size() <= n + i || bus_log[n+i] !== exp_log[i]) begin
        errors++;
        $display("FAIL streak_grant%0d: got %h, required %h", i, bus_log.size() > n + i ? bus_log[n+i] : 33'h0, exp_log[i]);
      end
    end
    checks++;
    if (dut.r_streak !== '0) begin
      errors++;
      $display("FAIL streak_clear: streak=%0d, required 0", dut.r_streak);
    end
  endtask

  task automatic test_flush;
    int  r0;
    bit  bad;
    rsp_delay = 3;
    bad = 0;
    @(posedge clk_i);
    #1;
    r0 = bus_rsp_cnt;
    if_req_i = 1'b1;
    if_addr_i = 32'h180;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    if_flush_i = 1'b1;
    if_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    if_flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (if_rvalid_o) bad = 1;
    end
    checks++;
    if (bad || bus_rsp_cnt != r0 + 1) begin
      errors++;
      $display("FAIL flush_rsp: rvalid_seen=%0d bus_rsps=%0d, required 0 1", bad, bus_rsp_cnt - r0);
    end
    rsp_delay = 1;
    @(posedge clk_i);
    #1;
    fetch(32'h40, pat(32'h40));
`ifdef CORE_ARB_PERF_EN
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL flush_drop_cnt: got %0d, required 1", drop_cnt);
    end
`endif
    if_req_i = 1'b1;
    if_addr_i = 32'h1C0;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    if_flush_i = 1'b1;
    if_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({bus_rvalid_i, if_rvalid_o} !== 2'b10) begin
      errors++;
      $display("FAIL flush_same_cycle: bus_rvalid=%b if_rvalid=%b, required 1 0", bus_rvalid_i, if_rvalid_o);
    end
    @(posedge clk_i);
    #1;
    if_flush_i = 1'b0;
`ifdef CORE_ARB_PERF_EN
    checks++;
    if (drop_cnt !== 16'd2) begin
      errors++;
      $display("FAIL flush_drop_cnt2: got %0d, required 2", drop_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid;
    rsp_delay = 2;
    @(posedge clk_i);
    #1;
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_addr_i = 32'h280;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    mem_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({bus_rvalid_i, mem_rvalid_o, if_rvalid_o, bus_req_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_stale: bus_rvalid=%b mem_rv=%b if_rv=%b bus_req=%b, required 1 0 0 0",
               bus_rvalid_i, mem_rvalid_o, if_rvalid_o, bus_req_o);
    end
    @(negedge clk_i);
    checks++;
    if (bus_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: bus_req_o=%b, required 0", bus_req_o);
    end
    rsp_delay = 1;
    @(posedge clk_i);
    #1;
    mem_op(1'b0, 32'h300, 32'h0, 4'h0, pat(32'h300));
  endtask

  task automatic test_gnt_wait;
    bit seen;
    seen = 0;
    gnt_delay = 5;
    @(posedge clk_i);
    #1;
    mem_q.push_back(pat(32'h340));
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_addr_i = 32'h340;
    mem_be_i = 4'hF;
    mem_wdata_i = 32'h1234_5678;
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, mem_stall_o, bus_gnt_i} !== {2'b10, 32'h340, 4'hF, 2'b10}) begin
        errors++;
        $display("FAIL gnt_wait_c%0d: req=%b we=%b addr=%h be=%h stall=%b gnt=%b, required 1 0 00000340 f 1 0",
                 i + 1, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, mem_stall_o, bus_gnt_i);
      end
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (mem_rvalid_o) seen = 1;
    end
    checks++;
    if (!seen || mem_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL gnt_wait_rsp: seen=%0d stall=%b, required 1 0", seen, mem_stall_o);
    end
    @(posedge clk_i);
    #1;
    mem_req_i = 1'b0;
    gnt_delay = 0;
  endtask

  initial begin
    rst_i = 1'b1;
    if_req_i = 1'b0;
    if_addr_i = '0;
    if_flush_i = 1'b0;
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    mem_addr_i = '0;
    mem_wdata_i = '0;
    mem_be_i = '0;
    fork
      forever begin
        @(negedge clk_i);
        if (if_rvalid_o) begin
          checks++;
          if (if_q.size() == 0) begin
            errors++;
            $display("FAIL if_unexpected: rvalid with rdata=%h, required no response", if_rdata_o);
          end else if (if_rdata_o !== if_q[0]) begin
            errors++;
            $display("FAIL if_rdata: got %h, required %h", if_rdata_o, if_q[0]);
          end
          if (if_q.size() != 0) void'(if_q.pop_front());
        end
        if (mem_rvalid_o) begin
          checks++;
          if (mem_q.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected: rvalid with rdata=%h, required no response", mem_rdata_o);
          end else if (mem_rdata_o !== mem_q[0]) begin
            errors++;
            $display("FAIL mem_rdata: got %h, required %h", mem_rdata_o, mem_q[0]);
          end
          if (mem_q.size() != 0) void'(mem_q.pop_front());
        end
      end
    join_none
    test_reset();
    test_single_fetch();
    test_conflict();
    test_streak();
    test_flush();
    test_reset_mid();
    test_gnt_wait();
    repeat (3) @(posedge clk_i);
    checks++;
    if (if_q.size() != 0 || mem_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: if_left=%0d mem_left=%0d, required 0 0", if_q.size(), mem_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
